fir_axilite_slave: RTL and testbench
====================================

Name: fir_axilite_slave

Overview:
- AXI-Lite responder for the FIR engine's configuration space; answers the AXI-Lite initiator traffic issued from the host side (testbench or CPU).
- Holds the ap_ctrl status/control register and the data_length register.
- Maps coefficient accesses onto the single-port tap BRAM and hands that BRAM to the FIR datapath while a run is in progress.
- Enforces the access rules while the engine is busy: tap reads return all-ones, tap and length writes are dropped.

Parameters:
pADDR_WIDTH, 12, AXI-Lite and tap BRAM address width
pDATA_WIDTH, 32, data width of AXI-Lite, registers and tap BRAM
Tape_Num, 11, number of coefficients; tap window is 0x20 .. 0x20+4*(Tape_Num-1)

Ports:
axis_clk  in  1  single clock for the block
axis_rst_n  in  1  asynchronous active-low reset
awvalid  in  1  write address valid
awaddr  in  pADDR_WIDTH  write byte address
awready  out  1  write address ready
wvalid  in  1  write data valid
wdata  in  pDATA_WIDTH  write data
wready  out  1  write data ready
arvalid  in  1  read address valid
araddr  in  pADDR_WIDTH  read byte address
arready  out  1  read address ready
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  pDATA_WIDTH  read data
tap_WE  out  4  tap BRAM byte write enables
tap_EN  out  1  tap BRAM enable
tap_Di  out  pDATA_WIDTH  tap BRAM write data
tap_A  out  pADDR_WIDTH  tap BRAM byte address
tap_Do  in  pDATA_WIDTH  tap BRAM read data, 1-cycle latency
eng_tap_A  in  pADDR_WIDTH  engine's tap address, used while busy
ap_start_o  out  1  one-cycle start pulse to the engine
data_length_o  out  pDATA_WIDTH  current data_length register
eng_done_i  in  1  one-cycle pulse when the engine has emitted its last output

Behaviour:
- Reset (asynchronous, axis_rst_n low): all outputs low except as noted; rdata=0; data_length=0; ap_done=0; ap_idle=1; FSM returns to IDLE.
- Reset asserted mid-transaction aborts it; no rvalid and no BRAM write is issued afterwards.

Address map:
- 0x00 ap_ctrl.
  - bit0 ap_start: write-1 pulse, reads 0.
  - bit1 ap_done: read-only, sticky; cleared by the read of 0x00 that returns it as 1.
  - bit2 ap_idle: read-only.
  - All other bits read 0.
- 0x10 data_length: read/write.
- 0x20 + 4*n, n < Tape_Num: coefficient n; tap_A = addr - 0x20.
- Any other address: reads return 0, writes are ignored but still completed.

Handshake and FSM (shared by write and read):
- IDLE:
  - If awvalid && wvalid, go to WR. Writes have priority over a simultaneous arvalid.
  - Else if arvalid, go to RA.
- WR: awready=wready=1 for exactly one cycle; address and data are sampled that cycle.
  - Tap address and idle: tap_EN=1, tap_WE=4'hF, tap_Di=wdata.
  - Next state: IDLE.
- RA: arready=1 for one cycle; araddr is captured.
  - Tap address and idle: tap_EN=1, tap_WE=0.
  - Next state: RW.
- RW: BRAM latency cycle. Next state: RD.
- RD: rvalid=1 and rdata held stable until rready; transaction completes on rvalid&&rready. Next state: IDLE.
- Read latency: arready handshake at cycle t gives rvalid at cycle t+2.
- No write is accepted while in RA, RW or RD.

Control and busy rules:
- busy = !ap_idle.
- Write to 0x00 with bit0=1 while idle: ap_start_o=1 for one cycle; ap_idle<=0 and ap_done<=0 on the same edge.
  - The same write while busy is ignored.
- While busy:
  - Writes to 0x10 and to taps are dropped and the BRAM is not written.
  - Tap reads return 32'hFFFFFFFF; the BRAM is not read on the AXI side.
  - Reads of 0x10 return data_length.
- BRAM ownership while busy: tap_A=eng_tap_A, tap_EN=1, tap_WE=0, driven combinationally from eng_tap_A.
- BRAM ownership while idle: FSM drives tap_A; tap_EN=0 outside the WR and RA cycles.
- eng_done_i: ap_done<=1 and ap_idle<=1.
  - If eng_done_i coincides with an ap_ctrl read in RD, the set wins; ap_done stays 1 for the next read.
- An ap_ctrl read latches its status value in RA.

Test Plan:
- Reset, read 0x00 -> rdata=0x4; read 0x10 -> 0; arready at t gives rvalid at t+2.
- Write 0x10=350, then taps 0x20..0x48 = {0,-10,-9,23,56,63,56,23,-9,-10,0}; read back -> exact values; each write gives tap_WE=4'hF with tap_A=0x00..0x28.
- Write 0x00=1 -> ap_start_o pulses for 1 cycle; next read of 0x00 -> 0x0; tap_A follows eng_tap_A.
- While busy: read 0x24 -> 0xFFFFFFFF; read 0x10 -> 350; write 0x24=123 and 0x10=7 -> both complete but stay dropped; after done, read 0x24 -> -10 and 0x10 -> 350.
- Pulse eng_done_i -> read 0x00 returns 0x6, a second read returns 0x4; rready held low 5 cycles -> rvalid and rdata stable throughout.
- awvalid/wvalid and arvalid raised in the same cycle -> write completes first, then read; assert axis_rst_n low during RW -> no rvalid, ap_idle=1.

Source files
------------

// File: rtl/fir_axilite_slave.sv
// AXI-Lite configuration responder for the FIR engine: ap_ctrl, data_length and
// coefficient access to the tap BRAM, which is handed to the engine while it runs.
module fir_axilite_slave #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   awready,
    input  logic                   wvalid,
    input  logic [pDATA_WIDTH-1:0] wdata,
    output logic                   wready,
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   arready,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    output logic                   ap_start_o,
    output logic [pDATA_WIDTH-1:0] data_length_o,
    input  logic                   eng_done_i
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RA, S_RW, S_RD} state_t;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP0 = pADDR_WIDTH'(32);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAPN = pADDR_WIDTH'(32 + 4 * (Tape_Num - 1));

    function automatic logic f_is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= ADDR_TAP0) && (a <= ADDR_TAPN) && (a[1:0] == 2'b00);
    endfunction

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_ap_idle;
    logic                     r_ap_done;
    logic [pDATA_WIDTH-1:0]   r_data_length;
    logic [pADDR_WIDTH-1:0]   r_araddr;
    logic                     r_rd_idle;
    logic                     r_snap_done;
    logic [pDATA_WIDTH-1:0]   r_rdata;
    logic [pDATA_WIDTH-1:0]   w_ctrl_rd;
    logic                     w_start;
    logic                     w_len_wr;
    logic                     w_ctrl_clr;

    assign w_start    = (r_state == S_WR) && (awaddr == ADDR_CTRL) && wdata[0] && r_ap_idle;
    assign w_len_wr   = (r_state == S_WR) && (awaddr == ADDR_LEN) && r_ap_idle;
    assign w_ctrl_clr = (r_state == S_RD) && rready && (r_araddr == ADDR_CTRL) && r_snap_done;

    assign rdata         = r_rdata;
    assign data_length_o = r_data_length;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // While busy the engine owns the BRAM; otherwise only WR/RA touch it.
    always_comb begin
        w_next     = r_state;
        awready    = 1'b0;
        wready     = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        ap_start_o = w_start;
        tap_EN     = 1'b0;
        tap_WE     = 4'h0;
        tap_Di     = '0;
        tap_A      = '0;
        case (r_state)
            S_IDLE: begin
                if (awvalid && wvalid) begin
                    w_next = S_WR;
                end else if (arvalid) begin
                    w_next = S_RA;
                end
            end
            S_WR: begin
                awready = 1'b1;
                wready  = 1'b1;
                w_next  = S_IDLE;
                if (r_ap_idle && f_is_tap(awaddr)) begin
                    tap_EN = 1'b1;
                    tap_WE = 4'hF;
                    tap_Di = wdata;
                    tap_A  = awaddr - ADDR_TAP0;
                end
            end
            S_RA: begin
                arready = 1'b1;
                w_next  = S_RW;
                if (r_ap_idle && f_is_tap(araddr)) begin
                    tap_EN = 1'b1;
                    tap_A  = araddr - ADDR_TAP0;
                end
            end
            S_RW: begin
                w_next = S_RD;
            end
            S_RD: begin
                rvalid = 1'b1;
                if (rready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (!r_ap_idle) begin
            tap_EN = 1'b1;
            tap_WE = 4'h0;
            tap_Di = '0;
            tap_A  = eng_tap_A;
        end
    end

    always_comb begin
        w_ctrl_rd    = '0;
        w_ctrl_rd[1] = r_snap_done;
        w_ctrl_rd[2] = r_rd_idle;
    end

    // A done pulse must win over the clear-on-read so no completion is lost.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_ap_idle     <= 1'b1;
            r_ap_done     <= 1'b0;
            r_data_length <= '0;
        end else begin
            if (eng_done_i) begin
                r_ap_done <= 1'b1;
                r_ap_idle <= 1'b1;
            end else if (w_start) begin
                r_ap_done <= 1'b0;
                r_ap_idle <= 1'b0;
            end else if (w_ctrl_clr) begin
                r_ap_done <= 1'b0;
            end
            if (w_len_wr) begin
                r_data_length <= wdata;
            end
        end
    end

    // Status and busy state are frozen at the address phase; data is muxed in RW.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_araddr    <= '0;
            r_rd_idle   <= 1'b0;
            r_snap_done <= 1'b0;
            r_rdata     <= '0;
        end else begin
            if (r_state == S_RA) begin
                r_araddr    <= araddr;
                r_rd_idle   <= r_ap_idle;
                r_snap_done <= r_ap_done;
            end
            if (r_state == S_RW) begin
                if (r_araddr == ADDR_CTRL) begin
                    r_rdata <= w_ctrl_rd;
                end else if (r_araddr == ADDR_LEN) begin
                    r_rdata <= r_data_length;
                end else if (f_is_tap(r_araddr)) begin
                    r_rdata <= r_rd_idle ? tap_Do : '1;
                end else begin
                    r_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_axilite_slave.sv
// Directed self-checking bench for fir_axilite_slave with a behavioural tap BRAM.
module tb_fir_axilite_slave;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [11:0] awaddr = '0, araddr = '0, eng_tap_A = '0;
    logic [31:0] wdata = '0;
    logic        awready, wready, arready, rvalid;
    logic [31:0] rdata, tap_Di, data_length_o;
    logic [31:0] tap_Do = '0;
    logic [3:0]  tap_WE;
    logic        tap_EN, ap_start_o;
    logic [11:0] tap_A;
    logic        eng_done_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int coef [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    logic [31:0] bram [0:1023];

    fir_axilite_slave #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
        .eng_tap_A(eng_tap_A), .ap_start_o(ap_start_o),
        .data_length_o(data_length_o), .eng_done_i(eng_done_i)
    );

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) cyc <= cyc + 1;

    always @(posedge axis_clk) begin
        if (tap_EN) begin
            for (int b = 0; b < 4; b++)
                if (tap_WE[b]) bram[tap_A[11:2]][8*b +: 8] <= tap_Di[8*b +: 8];
            tap_Do <= bram[tap_A[11:2]];
        end
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             output logic [3:0] we, output logic [11:0] ta, output logic st);
        bit got = 0;
        we = 4'h0; ta = '0; st = 1'b0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge axis_clk);
            if (awready && wready) begin
                got = 1; we = tap_WE; ta = tap_A; st = ap_start_o;
                break;
            end
        end
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n_checks++;
        if (!got) begin n_fail++; $display("[TB] FAIL write_handshake addr %h: got no awready, expected awready", a); end
    endtask

    task automatic axi_read(input logic [11:0] a, input int hold,
                            output logic [31:0] d, output int lat, output bit stable);
        bit got_ar = 0, got_r = 0;
        int t_ar = 0;
        d = '0; lat = -1; stable = 1;
        araddr = a; arvalid = 1'b1; rready = (hold == 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge axis_clk);
            if (arready) begin got_ar = 1; t_ar = cyc; break; end
        end
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 20 && got_ar; i++) begin
            @(negedge axis_clk);
            if (rvalid) begin got_r = 1; d = rdata; lat = cyc - t_ar; break; end
        end
        if (got_r && hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge axis_clk);
                if (!rvalid || rdata !== d) stable = 0;
            end
            rready = 1'b1;
        end
        @(posedge axis_clk); #1;
        rready = 1'b0;
        n_checks++;
        if (!got_r) begin n_fail++; $display("[TB] FAIL read_handshake addr %h: got no rvalid, expected rvalid", a); end
    endtask

    task automatic test_reset();
        logic [31:0] d; int lat; bit st;
        axis_rst_n = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1;
        n_checks++;
        if ({awready, wready, arready, rvalid, tap_EN, ap_start_o} !== 6'b0) begin
            n_fail++; $display("[TB] FAIL reset_ctrl_outs: got %b, expected 000000", {awready, wready, arready, rvalid, tap_EN, ap_start_o});
        end
        n_checks++;
        if (rdata !== 32'h0 || data_length_o !== 32'h0 || tap_WE !== 4'h0) begin
            n_fail++; $display("[TB] FAIL reset_data_outs: got rdata %h len %h we %h, expected all 0", rdata, data_length_o, tap_WE);
        end
        @(negedge axis_clk); axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;
        axi_read(12'h000, 0, d, lat, st);
        n_checks++;
        if (d !== 32'h4) begin n_fail++; $display("[TB] FAIL reset_ctrl_read: got %h, expected 00000004", d); end
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("[TB] FAIL read_latency: got %0d, expected 2", lat); end
        axi_read(12'h010, 0, d, lat, st);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_len_read: got %h, expected 00000000", d); end
    endtask

    task automatic test_taps();
        logic [3:0] we; logic [11:0] ta; logic st; logic [31:0] d; int lat; bit sb;
        axi_write(12'h010, 32'd350, we, ta, st);
        n_checks++;
        if (data_length_o !== 32'd350) begin n_fail++; $display("[TB] FAIL len_write: got %0d, expected 350", data_length_o); end
        for (int n = 0; n < 11; n++) begin
            axi_write(12'(32 + 4*n), 32'(coef[n]), we, ta, st);
            n_checks++;
            if (we !== 4'hF || ta !== 12'(4*n)) begin
                n_fail++; $display("[TB] FAIL tap_write_%0d: got we %h A %h, expected we f A %h", n, we, ta, 12'(4*n));
            end
        end
        for (int n = 0; n < 11; n++) begin
            axi_read(12'(32 + 4*n), 0, d, lat, sb);
            n_checks++;
            if (d !== 32'(coef[n])) begin n_fail++; $display("[TB] FAIL tap_read_%0d: got %h, expected %h", n, d, 32'(coef[n])); end
        end
        axi_write(12'h04C, 32'd5, we, ta, st);
        n_checks++;
        if (we !== 4'h0) begin n_fail++; $display("[TB] FAIL unmapped_write: got we %h, expected 0", we); end
        axi_read(12'h04C, 0, d, lat, sb);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL unmapped_read: got %h, expected 00000000", d); end
    endtask

    task automatic test_start();
        logic [3:0] we; logic [11:0] ta; logic st; logic [31:0] d; int lat; bit sb;
        axi_write(12'h000, 32'h1, we, ta, st);
        n_checks++;
        if (st !== 1'b1) begin n_fail++; $display("[TB] FAIL start_pulse: got %b, expected 1", st); end
        n_checks++;
        if (ap_start_o !== 1'b0) begin n_fail++; $display("[TB] FAIL start_one_cycle: got %b, expected 0", ap_start_o); end
        axi_read(12'h000, 0, d, lat, sb);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL busy_ctrl_read: got %h, expected 00000000", d); end
        eng_tap_A = 12'h014; #1;
        n_checks++;
        if (tap_A !== 12'h014 || tap_EN !== 1'b1 || tap_WE !== 4'h0) begin
            n_fail++; $display("[TB] FAIL eng_owns_bram: got A %h EN %b WE %h, expected A 014 EN 1 WE 0", tap_A, tap_EN, tap_WE);
        end
        eng_tap_A = 12'h008; #1;
        n_checks++;
        if (tap_A !== 12'h008) begin n_fail++; $display("[TB] FAIL eng_tap_follow: got %h, expected 008", tap_A); end
    endtask

    task automatic test_busy();
        logic [3:0] we; logic [11:0] ta; logic st; logic [31:0] d; int lat; bit sb;
        axi_read(12'h024, 0, d, lat, sb);
        n_checks++;
        if (d !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL busy_tap_read: got %h, expected ffffffff", d); end
        axi_read(12'h010, 0, d, lat, sb);
        n_checks++;
        if (d !== 32'd350) begin n_fail++; $display("[TB] FAIL busy_len_read: got %0d, expected 350", d); end
        axi_write(12'h024, 32'd123, we, ta, st);
        n_checks++;
        if (we !== 4'h0) begin n_fail++; $display("[TB] FAIL busy_tap_write_we: got %h, expected 0", we); end
        axi_write(12'h010, 32'd7, we, ta, st);
        n_checks++;
        if (data_length_o !== 32'd350) begin n_fail++; $display("[TB] FAIL busy_len_write: got %0d, expected 350", data_length_o); end
        axi_write(12'h000, 32'h1, we, ta, st);
        n_checks++;
        if (st !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_restart: got %b, expected 0", st); end
    endtask

    task automatic test_done();
        logic [31:0] d; int lat; bit sb;
        eng_done_i = 1'b1;
        @(posedge axis_clk); #1;
        eng_done_i = 1'b0;
        axi_read(12'h000, 5, d, lat, sb);
        n_checks++;
        if (d !== 32'h6) begin n_fail++; $display("[TB] FAIL done_ctrl_read: got %h, expected 00000006", d); end
        n_checks++;
        if (sb !== 1'b1) begin n_fail++; $display("[TB] FAIL rdata_stable: got %b, expected 1", sb); end
        axi_read(12'h000, 0, d, lat, sb);
        n_checks++;
        if (d !== 32'h4) begin n_fail++; $display("[TB] FAIL done_cleared: got %h, expected 00000004", d); end
        axi_read(12'h024, 0, d, lat, sb);
        n_checks++;
        if (d !== 32'hFFFFFFF6) begin n_fail++; $display("[TB] FAIL tap_kept: got %h, expected fffffff6", d); end
        axi_read(12'h010, 0, d, lat, sb);
        n_checks++;
        if (d !== 32'd350) begin n_fail++; $display("[TB] FAIL len_kept: got %0d, expected 350", d); end
    endtask

    task automatic test_back_to_back();
        bit saw_w = 0, saw_r = 0, order_ok = 1;
        logic [31:0] d = '0;
        awaddr = 12'h010; wdata = 32'd99; araddr = 12'h010;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 20 && !saw_r; i++) begin
            @(negedge axis_clk);
            if (awready) begin
                saw_w = 1;
                @(posedge axis_clk); #1;
                awvalid = 1'b0; wvalid = 1'b0;
            end else if (arready) begin
                saw_r = 1;
                if (!saw_w) order_ok = 0;
            end
        end
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge axis_clk);
            if (rvalid) begin d = rdata; break; end
        end
        @(posedge axis_clk); #1;
        rready = 1'b0;
        n_checks++;
        if (!(saw_w && saw_r && order_ok)) begin
            n_fail++; $display("[TB] FAIL write_priority: got w %b r %b order %b, expected 1 1 1", saw_w, saw_r, order_ok);
        end
        n_checks++;
        if (d !== 32'd99) begin n_fail++; $display("[TB] FAIL read_after_write: got %0d, expected 99", d); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] we; logic [11:0] ta; logic st; logic [31:0] d; int lat; bit sb;
        bit got = 0, quiet = 1;
        axi_write(12'h000, 32'h1, we, ta, st);
        araddr = 12'h010; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge axis_clk);
            if (arready) begin got = 1; break; end
        end
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        axis_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge axis_clk);
            if (rvalid || tap_WE !== 4'h0) quiet = 0;
        end
        axis_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge axis_clk);
            if (rvalid || tap_WE !== 4'h0) quiet = 0;
        end
        rready = 1'b0;
        @(posedge axis_clk); #1;
        n_checks++;
        if (!(got && quiet)) begin n_fail++; $display("[TB] FAIL reset_abort: got ar %b quiet %b, expected 1 1", got, quiet); end
        axi_read(12'h000, 0, d, lat, sb);
        n_checks++;
        if (d !== 32'h4) begin n_fail++; $display("[TB] FAIL reset_mid_idle: got %h, expected 00000004", d); end
        n_checks++;
        if (data_length_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mid_len: got %0d, expected 0", data_length_o); end
    endtask

    initial begin
        $display("[TB] starting fir_axilite_slave bench");
        test_reset();
        test_taps();
        test_start();
        test_busy();
        test_done();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
